// File: rtl/cpu_subsys_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : cpu_subsys_mem_arb
// Description : Two-master round-robin arbiter in front of a single native
//               memory bus slave, with registered slave-side request fields.
//               The optional BUSY timeout abort is enabled by defining
//               CPU_SUBSYS_MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_subsys_mem_arb #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic        timeout
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_BUSY = 2'd1;
   localparam logic [1:0] c_GAP  = 2'd2;

   logic [1:0]  r_state;
   logic        r_grant;
   logic        r_last_grant;
   logic        r_s_valid;
   logic [31:0] r_s_addr;
   logic [31:0] r_s_wdata;
   logic [3:0]  r_s_wstrb;

   logic        w_any_req;
   logic        w_winner;
   logic        w_busy;
   logic        w_timeout;
   logic        w_done;
   logic [31:0] w_rdata;

   assign w_any_req = m0_valid | m1_valid;
   // On a tie the master that did not win last time is served; 1 = m1.
   assign w_winner  = (m0_valid && m1_valid) ? ~r_last_grant : m1_valid;
   assign w_busy    = (r_state == c_BUSY);

`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
   localparam int unsigned      c_TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_TW-1:0]  c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

   logic [c_TW-1:0] r_tcnt;

   // Counter holds k-1 in the k-th BUSY cycle, so expiry lands in cycle TIMEOUT_CYCLES.
   assign w_timeout = w_busy && !s_ready && (r_tcnt == c_TLAST);
   assign w_rdata   = w_timeout ? ERR_RDATA : s_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tcnt <= '0;
      end else if (r_state == c_IDLE) begin
         r_tcnt <= '0;
      end else if (w_busy && !s_ready) begin
         r_tcnt <= r_tcnt + c_TW'(1);
      end
   end
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^{ERR_RDATA, 32'(TIMEOUT_CYCLES)};
   assign w_timeout    = 1'b0;
   assign w_rdata      = s_rdata;
`endif

   assign w_done = w_busy && (s_ready || w_timeout);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_s_valid    <= 1'b0;
         r_s_addr     <= '0;
         r_s_wdata    <= '0;
         r_s_wstrb    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_grant      <= w_winner;
                  r_last_grant <= w_winner;
                  r_s_valid    <= 1'b1;
                  r_s_addr     <= w_winner ? m1_addr  : m0_addr;
                  r_s_wdata    <= w_winner ? m1_wdata : m0_wdata;
                  r_s_wstrb    <= w_winner ? m1_wstrb : m0_wstrb;
                  r_state      <= c_BUSY;
               end
            end
            c_BUSY: begin
               if (w_done) begin
                  r_s_valid <= 1'b0;
                  r_state   <= c_GAP;
               end
            end
            // The slave's ready may still be high here from the last beat.
            c_GAP:   r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign s_valid  = r_s_valid;
   assign s_addr   = r_s_addr;
   assign s_wdata  = r_s_wdata;
   assign s_wstrb  = r_s_wstrb;
   assign timeout  = w_timeout;

   assign m0_ready = w_done && !r_grant;
   assign m1_ready = w_done &&  r_grant;
   assign m0_rdata = (w_busy && !r_grant) ? w_rdata : 32'd0;
   assign m1_rdata = (w_busy &&  r_grant) ? w_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_subsys_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_subsys_mem_arb
// Description : Directed self-checking bench for cpu_subsys_mem_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_subsys_mem_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid;
   logic        s_ready = 1'b0;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] s_rdata = '0;
   logic        timeout;

   int n_chk  = 0;
   int n_fail = 0;

   cpu_subsys_mem_arb #(
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_valid (m0_valid),
      .m0_ready (m0_ready),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_wstrb (m0_wstrb),
      .m0_rdata (m0_rdata),
      .m1_valid (m1_valid),
      .m1_ready (m1_ready),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_wstrb (m1_wstrb),
      .m1_rdata (m1_rdata),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wstrb  (s_wstrb),
      .s_rdata  (s_rdata),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Entered in an IDLE cycle with the requests already driven; the slave
   // answers one cycle after s_valid and optionally leaves ready high in GAP.
   task automatic run_xact(input logic exp_m1, input logic [31:0] exp_addr,
                           input logic [31:0] rd, input logic stale_ready);
      tick();
      s_ready = 1'b0;
      #1;
      chk1("grant_s_valid", s_valid, 1'b1);
      chk32("grant_s_addr", s_addr, exp_addr);
      chk1("busy_m0_ready", m0_ready, 1'b0);
      chk1("busy_m1_ready", m1_ready, 1'b0);
      tick();
      s_ready = 1'b1;
      s_rdata = rd;
      #1;
      chk1("done_m0_ready", m0_ready, !exp_m1);
      chk1("done_m1_ready", m1_ready, exp_m1);
      chk32("done_rdata", exp_m1 ? m1_rdata : m0_rdata, rd);
      chk32("done_other_rdata", exp_m1 ? m0_rdata : m1_rdata, 32'd0);
      chk1("done_timeout", timeout, 1'b0);
      tick();
      s_ready = stale_ready;
      #1;
      chk1("gap_s_valid", s_valid, 1'b0);
      chk1("gap_m0_ready", m0_ready, 1'b0);
      chk1("gap_m1_ready", m1_ready, 1'b0);
      tick();
      s_ready = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk1("rst_s_valid", s_valid, 1'b0);
      chk32("rst_s_addr", s_addr, 32'd0);
      chk32("rst_s_wdata", s_wdata, 32'd0);
      chk32("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
      chk1("rst_m0_ready", m0_ready, 1'b0);
      chk1("rst_m1_ready", m1_ready, 1'b0);
      chk1("rst_timeout", timeout, 1'b0);
      rst = 1'b0;

      // m0 single read; m0 keeps valid through GAP, which must not re-grant
      m0_valid = 1'b1;
      m0_addr  = 32'h0000_0010;
      run_xact(1'b0, 32'h0000_0010, 32'h1234_5678, 1'b1);
      m0_valid = 1'b0;
      tick();
      chk1("no_regrant_s_valid", s_valid, 1'b0);
      chk1("no_regrant_m0_ready", m0_ready, 1'b0);

      // Tie from reset: m0, m1, m0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m0_valid = 1'b1;
      m0_addr  = 32'h0000_0100;
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0200;
      run_xact(1'b0, 32'h0000_0100, 32'h0000_0A00, 1'b0);
      run_xact(1'b1, 32'h0000_0200, 32'h0000_0B00, 1'b0);
      run_xact(1'b0, 32'h0000_0100, 32'h0000_0C00, 1'b0);
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      tick();

      // Slave ready held high: one pulse only, GAP quiet
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0300;
      s_ready  = 1'b1;
      s_rdata  = 32'h5555_AAAA;
      tick();
      chk1("hold_s_valid", s_valid, 1'b1);
      chk1("hold_m1_ready", m1_ready, 1'b1);
      chk1("hold_m0_ready", m0_ready, 1'b0);
      chk32("hold_m1_rdata", m1_rdata, 32'h5555_AAAA);
      tick();
      chk1("hold_gap_s_valid", s_valid, 1'b0);
      chk1("hold_gap_m1_ready", m1_ready, 1'b0);
      m1_valid = 1'b0;
      tick();
      chk1("hold_idle_m1_ready", m1_ready, 1'b0);
      s_ready = 1'b0;
      tick();
      chk1("hold_idle_s_valid", s_valid, 1'b0);

      // m1 write, slow slave
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0040;
      m1_wdata = 32'hAABB_CCDD;
      m1_wstrb = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk32("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
         chk32("wr_s_wstrb", {28'd0, s_wstrb}, 32'h3);
         chk1("wr_wait_m1_ready", m1_ready, 1'b0);
      end
      tick();
      s_ready = 1'b1;
      #1;
      chk1("wr_m1_ready", m1_ready, 1'b1);
      chk32("wr_s_wstrb_end", {28'd0, s_wstrb}, 32'h3);
      tick();
      s_ready  = 1'b0;
      m1_valid = 1'b0;
      m1_wstrb = 4'b0000;
      #1;
      chk1("wr_gap_s_valid", s_valid, 1'b0);
      tick();

      // Reset while BUSY
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0080;
      tick();
      chk1("rb_s_valid", s_valid, 1'b1);
      chk32("rb_s_addr", s_addr, 32'h0000_0080);
      rst = 1'b1;
      tick();
      chk1("rb_after_s_valid", s_valid, 1'b0);
      chk32("rb_after_s_addr", s_addr, 32'd0);
      s_ready = 1'b1;
      #1;
      chk1("rb_m1_ready", m1_ready, 1'b0);
      chk1("rb_m0_ready", m0_ready, 1'b0);
      s_ready  = 1'b0;
      rst      = 1'b0;
      m0_valid = 1'b1;
      m0_addr  = 32'h0000_0090;
      run_xact(1'b0, 32'h0000_0090, 32'h0BAD_F00D, 1'b0);
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      tick();

`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
      // Silent slave: abort in the 8th BUSY cycle
      m0_valid = 1'b1;
      m0_addr  = 32'h0000_0020;
      tick();
      for (int i = 1; i < 8; i++) begin
         chk1("to_wait_m0_ready", m0_ready, 1'b0);
         chk1("to_wait_timeout", timeout, 1'b0);
         tick();
      end
      chk1("to_m0_ready", m0_ready, 1'b1);
      chk32("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk1("to_pulse", timeout, 1'b1);
      tick();
      chk1("to_gap_timeout", timeout, 1'b0);
      chk1("to_gap_s_valid", s_valid, 1'b0);
      m0_valid = 1'b0;
      tick();
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0024;
      run_xact(1'b1, 32'h0000_0024, 32'h0000_0077, 1'b0);
      m1_valid = 1'b0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_subsys_mem_arb.md
Name: cpu_subsys_mem_arb

Overview:
- Two-master, one-slave arbiter on the CPU-subsystem native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Shares a single memory target, such as the boot ROM, between the CPU (m0) and a debug/loader master (m1).
- Round-robin grant; request fields registered toward the slave.
- Hides the slave's registered-ready behaviour: a ready that stays high while valid is held is never seen twice.

Parameters:
- TIMEOUT_CYCLES, 256, BUSY cycles without s_ready before the abort (used only when the optional feature is compiled in).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timeout abort.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- m0_valid/m1_valid  input  1  master request
- m0_ready/m1_ready  output  1  master completion strobe
- m0_addr/m1_addr  input  32  byte address
- m0_wdata/m1_wdata  input  32  write data
- m0_wstrb/m1_wstrb  input  4  byte strobes (0 = read)
- m0_rdata/m1_rdata  output  32  read data
- s_valid  output  1  slave request (registered)
- s_ready  input  1  slave completion
- s_addr  output  32  latched address
- s_wdata  output  32  latched write data
- s_wstrb  output  4  latched strobes
- s_rdata  input  32  slave read data
- timeout  output  1  one-cycle pulse on abort; constant 0 without the optional feature

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - state=IDLE, s_valid=0, s_addr/s_wdata/s_wstrb=0, last_grant=1 (so m0 wins the first tie), timeout=0.
  - m*_ready=0.
  - A reset mid-transaction drops the transaction silently; no ready goes to any master.
- State machine:
  - IDLE: if any m*_valid, pick the winner. A sole requester wins. If both request, the master != last_grant wins.
    - Next cycle: latch the winner's addr/wdata/wstrb into s_*, set s_valid=1, store grant, set last_grant=winner, go to BUSY.
    - If no request, stay in IDLE.
  - BUSY: s_valid held at 1 with s_* fields stable.
    - On s_ready=1: m[grant]_ready=1 combinationally in that cycle, m[grant]_rdata=s_rdata.
    - Next cycle: s_valid=0, go to GAP.
  - GAP: exactly one cycle; s_ready ignored (stale registered ready); no grant; go to IDLE.
- Master outputs:
  - m*_rdata equals s_rdata when that master is granted, else 0.
  - The non-granted m*_ready is always 0.
  - At most one m*_ready is high in any cycle.
- Latency and throughput:
  - Master valid sampled in IDLE at cycle t; s_valid high at t+1.
  - With a ROM-type slave (ready one cycle after valid), m_ready is high at t+2.
  - GAP at t+3, IDLE at t+4.
  - Minimum 4 cycles between back-to-back grants.
- Master contract: a master holds valid and its fields stable until its ready. It drops valid no later than the cycle after ready, i.e. within the GAP cycle; the arbiter does not re-grant from that stale valid.
- A master deasserting valid while pending and not yet granted is simply not granted. Deasserting after grant is illegal; the transaction completes regardless.
- Writes: wstrb is passed through unchanged; the arbiter does not interpret reads vs writes.

Optional Feature:
- Macro: CPU_SUBSYS_MEM_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES: m[grant]_ready=1, m[grant]_rdata=ERR_RDATA, timeout=1 for that cycle, s_valid=0 next cycle, go to GAP.
  - s_ready in the same cycle as expiry takes priority: normal completion, no timeout pulse.
- When undefined: no counter, BUSY waits indefinitely, timeout tied to 0.

Test Plan:
- m0 read only, addr 0x0000_0010, slave returns 0x1234_5678 one cycle after s_valid -> s_addr=0x10 at t+1; m0_ready and m0_rdata=0x1234_5678 at t+2; m1_ready stays 0.
- m0 and m1 both request from reset, addrs 0x100 and 0x200 -> first s_addr=0x100 (m0), second s_addr=0x200 (m1), 4 cycles apart; with continued requests grants alternate m0,m1,m0.
- Slave holds s_ready high continuously while s_valid is high -> exactly one m_ready pulse per transaction; GAP cycle shows s_valid=0 and no ready.
- m1 write, wstrb=4'b0011, wdata=0xAABB_CCDD -> s_wstrb=4'b0011 and s_wdata=0xAABB_CCDD stable throughout BUSY; m1_ready when s_ready.
- rst asserted in BUSY before s_ready -> next cycle s_valid=0, state IDLE, no m*_ready; the following tie grants m0.
- With CPU_SUBSYS_MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never readies -> m0_ready with rdata=0xDEAD_BEEF and a one-cycle timeout pulse in the 8th BUSY cycle without s_ready; next grant proceeds normally.
